conf_pkt_parser: RTL and testbench



---
 rtl/conf_pkt_parser.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_conf_pkt_parser.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conf_pkt_parser.sv
`default_nettype none
// ============================================================================
// conf_pkt_parser : receive endpoint for 134-bit configuration packets; drives
//                   TCM writes/reads and core run control, returns read replies.
// Revision        : 1.0
// ============================================================================
module conf_pkt_parser #(
  parameter int TCM_AW = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pkt_in_valid,
  input  logic [133:0]      pkt_in,
  output logic              pkt_out_valid,
  output logic [133:0]      pkt_out,
  output logic              mem_wren,
  output logic              mem_rden,
  output logic [TCM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              cpu_run,
  output logic [15:0]       err_cnt
);

  localparam logic [1:0]  C_TAG_HEAD  = 2'b01;
  localparam logic [1:0]  C_TAG_MID   = 2'b11;
  localparam logic [1:0]  C_TAG_TAIL  = 2'b10;
  localparam logic [15:0] C_TYPE_RUN  = 16'h9001;
  localparam logic [15:0] C_TYPE_STAT = 16'h9002;
  localparam logic [15:0] C_TYPE_WR   = 16'h9003;
  localparam logic [15:0] C_TYPE_RD   = 16'h9004;

  typedef enum logic [2:0] {
    P_IDLE = 3'd0,
    P_META = 3'd1,
    P_TYPE = 3'd2,
    P_BODY = 3'd3,
    P_DROP = 3'd4
  } pstate_t;

  typedef enum logic [2:0] {
    R_IDLE = 3'd0,
    R_WAIT = 3'd1,
    R_HEAD = 3'd2,
    R_META = 3'd3,
    R_TYPE = 3'd4,
    R_TAIL = 3'd5
  } rstate_t;

  pstate_t            pstate_q, pstate_d;
  rstate_t            rstate_q, rstate_d;
  logic [15:0]        type_q, type_d;
  logic               first_q, first_d;
  logic [31:0]        rd_addr_q, rd_addr_d;
  logic               cpu_run_q, cpu_run_d;
  logic [31:0]        wr_cnt_q, wr_cnt_d;
  logic [15:0]        err_cnt_q, err_cnt_d;
  logic               mem_wren_q, mem_wren_d;
  logic               mem_rden_q, mem_rden_d;
  logic [TCM_AW-1:0]  mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic               rd_pend_q, rd_pend_d;
  logic [15:0]        rtype_q, rtype_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [31:0]        raddr_q, raddr_d;

  logic [1:0]         w_tag;
  logic               w_is_tail;
  logic [15:0]        w_type;
  logic [31:0]        w_data;
  logic [31:0]        w_addr;
  logic               w_wr_en;
  logic               w_perr;
  logic               w_rerr;
  logic               w_trig_rd;
  logic               w_trig_st;
  logic [31:0]        w_trig_addr;
  logic               w_unused;

  assign w_tag     = pkt_in[133:132];
  assign w_is_tail = (w_tag == C_TAG_TAIL);
  assign w_type    = pkt_in[31:16];
  assign w_data    = pkt_in[79:48];
  assign w_addr    = pkt_in[47:16];
  assign w_unused  = ^{pkt_in[131:128], pkt_in[127:80], pkt_in[15:0]};

  // Packet parser: framing, type decode and per-type body actions.
  always_comb begin
    pstate_d    = pstate_q;
    type_d      = type_q;
    first_d     = first_q;
    rd_addr_d   = rd_addr_q;
    cpu_run_d   = cpu_run_q;
    wr_cnt_d    = wr_cnt_q;
    w_wr_en     = 1'b0;
    w_perr      = 1'b0;
    w_trig_rd   = 1'b0;
    w_trig_st   = 1'b0;
    w_trig_addr = rd_addr_q;
    if (pkt_in_valid) begin
      if (w_tag == C_TAG_HEAD) begin
        w_perr   = (pstate_q != P_IDLE);
        pstate_d = P_META;
      end else if (w_tag == C_TAG_MID || w_tag == C_TAG_TAIL) begin
        case (pstate_q)
          P_IDLE: w_perr = 1'b1;
          P_META: begin
            if (w_is_tail) begin
              w_perr   = 1'b1;
              pstate_d = P_IDLE;
            end else begin
              pstate_d = P_TYPE;
            end
          end
          P_TYPE: begin
            if (w_is_tail) begin
              w_perr   = 1'b1;
              pstate_d = P_IDLE;
            end else begin
              type_d  = w_type;
              first_d = 1'b1;
              if (w_type == C_TYPE_RUN || w_type == C_TYPE_STAT ||
                  w_type == C_TYPE_WR  || w_type == C_TYPE_RD) begin
                pstate_d = P_BODY;
              end else begin
                w_perr   = 1'b1;
                pstate_d = P_DROP;
              end
            end
          end
          P_BODY: begin
            first_d = 1'b0;
            case (type_q)
              C_TYPE_RUN: begin
                if (first_q) cpu_run_d = pkt_in[16];
              end
              C_TYPE_WR: begin
                w_wr_en  = 1'b1;
                wr_cnt_d = wr_cnt_q + 32'd1;
              end
              C_TYPE_RD: begin
                // The tail may itself be the first body flit.
                if (first_q) begin
                  rd_addr_d   = w_addr;
                  w_trig_addr = w_addr;
                end
                w_trig_rd = w_is_tail;
              end
              C_TYPE_STAT: w_trig_st = w_is_tail;
              default: ;
            endcase
            if (w_is_tail) pstate_d = P_IDLE;
          end
          P_DROP: begin
            if (w_is_tail) pstate_d = P_IDLE;
          end
          default: pstate_d = P_IDLE;
        endcase
      end
    end
  end

  // Reply sequencer and TCM strobe generation.
  always_comb begin
    rstate_d    = rstate_q;
    rtype_d     = rtype_q;
    rdata_d     = rdata_q;
    raddr_d     = raddr_q;
    rd_pend_d   = mem_rden_q;
    mem_wren_d  = w_wr_en;
    mem_rden_d  = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    w_rerr      = 1'b0;
    if (w_wr_en) begin
      mem_addr_d  = w_addr[TCM_AW-1:0];
      mem_wdata_d = w_data;
    end
    case (rstate_q)
      // rd_pend_q marks the cycle in which the TCM presents read data.
      R_WAIT: begin
        if (rd_pend_q) begin
          rdata_d  = mem_rdata;
          rstate_d = R_HEAD;
        end
      end
      R_HEAD:  rstate_d = R_META;
      R_META:  rstate_d = R_TYPE;
      R_TYPE:  rstate_d = R_TAIL;
      default: rstate_d = R_IDLE;
    endcase
    if (w_trig_rd || w_trig_st) begin
      if (rstate_q != R_IDLE) begin
        w_rerr = 1'b1;
      end else if (w_trig_rd) begin
        rstate_d   = R_WAIT;
        mem_rden_d = 1'b1;
        mem_addr_d = w_trig_addr[TCM_AW-1:0];
        rtype_d    = C_TYPE_RD;
        raddr_d    = w_trig_addr;
      end else begin
        rstate_d = R_HEAD;
        rtype_d  = C_TYPE_STAT;
        rdata_d  = wr_cnt_q;
        raddr_d  = 32'd0;
      end
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((w_perr || w_rerr) && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_comb begin
    pkt_out_valid = 1'b0;
    pkt_out       = '0;
    case (rstate_q)
      R_HEAD: begin
        pkt_out_valid = 1'b1;
        pkt_out       = {C_TAG_HEAD, 132'd0};
      end
      R_META: begin
        pkt_out_valid = 1'b1;
        pkt_out       = {C_TAG_MID, 132'd0};
      end
      R_TYPE: begin
        pkt_out_valid = 1'b1;
        pkt_out       = {C_TAG_MID, 4'd0, 96'd0, rtype_q, 16'd0};
      end
      R_TAIL: begin
        pkt_out_valid = 1'b1;
        pkt_out       = {C_TAG_TAIL, 4'd0, 48'd0, rdata_q, raddr_q, 16'd0};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pstate_q    <= P_IDLE;
      rstate_q    <= R_IDLE;
      type_q      <= 16'd0;
      first_q     <= 1'b0;
      rd_addr_q   <= 32'd0;
      cpu_run_q   <= 1'b0;
      wr_cnt_q    <= 32'd0;
      err_cnt_q   <= 16'd0;
      mem_wren_q  <= 1'b0;
      mem_rden_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      rd_pend_q   <= 1'b0;
      rtype_q     <= 16'd0;
      rdata_q     <= 32'd0;
      raddr_q     <= 32'd0;
    end else begin
      pstate_q    <= pstate_d;
      rstate_q    <= rstate_d;
      type_q      <= type_d;
      first_q     <= first_d;
      rd_addr_q   <= rd_addr_d;
      cpu_run_q   <= cpu_run_d;
      wr_cnt_q    <= wr_cnt_d;
      err_cnt_q   <= err_cnt_d;
      mem_wren_q  <= mem_wren_d;
      mem_rden_q  <= mem_rden_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_pend_q   <= rd_pend_d;
      rtype_q     <= rtype_d;
      rdata_q     <= rdata_d;
      raddr_q     <= raddr_d;
    end
  end

  assign mem_wren  = mem_wren_q;
  assign mem_rden  = mem_rden_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_run   = cpu_run_q;
  assign err_cnt   = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_conf_pkt_parser.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_conf_pkt_parser : packet-level reference model and TCM model for conf_pkt_parser.
// Revision           : 1.0
// ============================================================================
module tb_conf_pkt_parser;

  localparam int         TCM_AW = 10;
  localparam logic [1:0] C_H = 2'b01;
  localparam logic [1:0] C_M = 2'b11;
  localparam logic [1:0] C_T = 2'b10;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              pkt_in_valid = 1'b0;
  logic [133:0]      pkt_in = '0;
  logic              pkt_out_valid;
  logic [133:0]      pkt_out;
  logic              mem_wren;
  logic              mem_rden;
  logic [TCM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              cpu_run;
  logic [15:0]       err_cnt;

  conf_pkt_parser #(.TCM_AW(TCM_AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .pkt_in_valid (pkt_in_valid),
    .pkt_in       (pkt_in),
    .pkt_out_valid(pkt_out_valid),
    .pkt_out      (pkt_out),
    .mem_wren     (mem_wren),
    .mem_rden     (mem_rden),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .cpu_run      (cpu_run),
    .err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { int t; logic [31:0] a; logic [31:0] d; } ev_t;
  typedef struct { int t; logic [133:0] f; } fl_t;

  int          vectors = 0;
  int          miscompares = 0;
  int          ncyc = 0;
  int          junk = 0;
  ev_t         wq[$], rq[$], ew[$], er[$];
  fl_t         oq[$], eo[$];
  ev_t         m_e;
  fl_t         m_f;
  logic [31:0] tcm [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] ref_wr_cnt;
  logic        ref_run;
  int          ref_err;
  logic [31:0] b_a[$], b_d[$];
  int          bt[$];

  // Synchronous TCM: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_wren) tcm[mem_addr] <= mem_wdata;
    if (mem_rden) mem_rdata <= tcm[mem_addr];
  end

  always @(negedge clk) begin
    if (mem_wren) begin
      m_e.t = ncyc; m_e.a = 32'(mem_addr); m_e.d = mem_wdata;
      wq.push_back(m_e);
    end
    if (mem_rden) begin
      m_e.t = ncyc; m_e.a = 32'(mem_addr); m_e.d = 32'd0;
      rq.push_back(m_e);
    end
    if (pkt_out_valid) begin
      m_f.t = ncyc; m_f.f = pkt_out;
      oq.push_back(m_f);
    end else if (pkt_out !== '0) begin
      junk <= junk + 1;
    end
    if (reset && (mem_wren || mem_rden || pkt_out_valid)) junk <= junk + 1;
    ncyc <= ncyc + 1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [133:0] obs, input logic [133:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [133:0] rep(input int k, input logic [15:0] typ,
                                       input logic [31:0] d, input logic [31:0] a);
    case (k)
      0:       return {2'b01, 132'd0};
      1:       return {2'b11, 132'd0};
      2:       return {2'b11, 4'd0, 96'd0, typ, 16'd0};
      default: return {2'b10, 4'd0, 48'd0, d, a, 16'd0};
    endcase
  endfunction

  task automatic put(input logic [1:0] tag, input logic [127:0] pl, output int t);
    pkt_in_valid = 1'b1;
    pkt_in       = {tag, 4'($urandom), pl};
    @(posedge clk);
    #1;
    t = ncyc;
    pkt_in_valid = 1'b0;
    pkt_in       = {2'($urandom), 4'd0, r128()};
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      pkt_in_valid = 1'b0;
      pkt_in       = {2'($urandom), 4'd0, r128()};
      @(posedge clk);
      #1;
    end
  endtask

  task automatic gap(input bit gaps);
    if (gaps) idle($urandom_range(0, 2));
  endtask

  task automatic send_pkt(input logic [15:0] typ, input bit close, input bit gaps);
    int t;
    logic [127:0] p;
    bt.delete();
    put(C_H, r128(), t); gap(gaps);
    put(C_M, r128(), t); gap(gaps);
    p = r128(); p[31:16] = typ;
    put(C_M, p, t); gap(gaps);
    for (int j = 0; j < b_a.size(); j++) begin
      p = r128(); p[79:48] = b_d[j]; p[47:16] = b_a[j];
      put((close && j == b_a.size() - 1) ? C_T : C_M, p, t);
      bt.push_back(t);
      if (j < b_a.size() - 1) gap(gaps);
    end
  endtask

  task automatic set_rand_bodies(input int n);
    b_a.delete(); b_d.delete();
    for (int j = 0; j < n; j++) begin
      b_a.push_back($urandom);
      b_d.push_back($urandom);
    end
  endtask

  task automatic do_write(input bit close, input bit gaps);
    ev_t e;
    send_pkt(16'h9003, close, gaps);
    for (int j = 0; j < b_a.size(); j++) begin
      e.t = bt[j]; e.a = {22'd0, b_a[j][9:0]}; e.d = b_d[j];
      ew.push_back(e);
      ref_mem[b_a[j][9:0]] = b_d[j];
      ref_wr_cnt = ref_wr_cnt + 32'd1;
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input int n);
    ev_t e;
    fl_t f;
    int  t;
    set_rand_bodies(n);
    b_a[0] = addr;
    send_pkt(16'h9004, 1'b1, 1'b1);
    t = bt[bt.size() - 1];
    e.t = t; e.a = {22'd0, addr[9:0]}; e.d = 32'd0;
    er.push_back(e);
    for (int k = 0; k < 4; k++) begin
      f.t = t + 2 + k;
      f.f = rep(k, 16'h9004, ref_mem[addr[9:0]], addr);
      eo.push_back(f);
    end
  endtask

  task automatic do_stat(input bit gaps);
    fl_t f;
    int  t;
    send_pkt(16'h9002, 1'b1, gaps);
    t = bt[bt.size() - 1];
    for (int k = 0; k < 4; k++) begin
      f.t = t + k;
      f.f = rep(k, 16'h9002, ref_wr_cnt, 32'd0);
      eo.push_back(f);
    end
  endtask

  task automatic do_run(input bit v, input int n);
    int t;
    logic [127:0] p;
    put(C_H, r128(), t);
    put(C_M, r128(), t);
    p = r128(); p[31:16] = 16'h9001;
    put(C_M, p, t);
    for (int j = 0; j < n; j++) begin
      p = r128(); p[16] = (j == 0) ? v : ~v;
      put((j == n - 1) ? C_T : C_M, p, t);
      if (j == 0) chk("run_latency", 134'(cpu_run), 134'(v));
    end
    ref_run = v;
  endtask

  task automatic check_all(input string tag);
    idle(8);
    chk({tag, " wr_count"}, 134'(wq.size()), 134'(ew.size()));
    for (int i = 0; i < ew.size(); i++) begin
      if (i < wq.size()) begin
        chk({tag, " wr_cycle"}, 134'(wq[i].t), 134'(ew[i].t));
        chk({tag, " wr_addr"},  134'(wq[i].a), 134'(ew[i].a));
        chk({tag, " wr_data"},  134'(wq[i].d), 134'(ew[i].d));
      end
    end
    chk({tag, " rd_count"}, 134'(rq.size()), 134'(er.size()));
    for (int i = 0; i < er.size(); i++) begin
      if (i < rq.size()) begin
        chk({tag, " rd_cycle"}, 134'(rq[i].t), 134'(er[i].t));
        chk({tag, " rd_addr"},  134'(rq[i].a), 134'(er[i].a));
      end
    end
    chk({tag, " reply_count"}, 134'(oq.size()), 134'(eo.size()));
    for (int i = 0; i < eo.size(); i++) begin
      if (i < oq.size()) begin
        chk({tag, " reply_cycle"}, 134'(oq[i].t), 134'(eo[i].t));
        chk({tag, " reply_flit"},  oq[i].f, eo[i].f);
      end
    end
    chk({tag, " cpu_run"}, 134'(cpu_run), 134'(ref_run));
    chk({tag, " err_cnt"}, 134'(err_cnt), 134'(16'(ref_err)));
    chk({tag, " idle_outputs"}, 134'(junk), 134'(0));
    wq.delete(); rq.delete(); oq.delete();
    ew.delete(); er.delete(); eo.delete();
  endtask

  initial begin
    int          t;
    logic [31:0] a;
    ref_err    = 0;
    ref_run    = 1'b0;
    ref_wr_cnt = 32'd0;
    reset      = 1'b1;
    idle(3);
    chk("rst pkt_out_valid", 134'(pkt_out_valid), 134'(0));
    chk("rst pkt_out", pkt_out, 134'(0));
    chk("rst mem_wren", 134'(mem_wren), 134'(0));
    chk("rst mem_rden", 134'(mem_rden), 134'(0));
    chk("rst mem_addr", 134'(mem_addr), 134'(0));
    chk("rst mem_wdata", 134'(mem_wdata), 134'(0));
    chk("rst cpu_run", 134'(cpu_run), 134'(0));
    chk("rst err_cnt", 134'(err_cnt), 134'(0));
    reset = 1'b0;
    idle(2);

    // Fill the whole TCM in one back-to-back packet; address 128 holds the read pattern.
    b_a.delete(); b_d.delete();
    for (int i = 0; i < 1024; i++) begin
      b_a.push_back(32'(i));
      b_d.push_back((i == 128) ? 32'hDEADBEEF : $urandom);
    end
    do_write(1'b1, 1'b0);
    check_all("wr1024");

    do_run(1'b1, 3);
    check_all("run_on");
    do_run(1'b0, 1);
    check_all("run_off");

    do_read(32'd128, 2);
    check_all("rd128");

    set_rand_bodies(2);
    do_stat(1'b0);
    check_all("stat1024");

    for (int it = 0; it < 12; it++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          set_rand_bodies($urandom_range(1, 6));
          do_write(1'b1, 1'b1);
        end
        2: do_read($urandom, $urandom_range(1, 3));
        default: begin
          set_rand_bodies($urandom_range(1, 3));
          do_stat(1'b1);
        end
      endcase
      check_all("random");
    end

    // Unknown type, head aborting a write packet, stray tail.
    set_rand_bodies(2);
    send_pkt(16'h1234, 1'b1, 1'b0);
    ref_err++;
    set_rand_bodies(3);
    do_write(1'b0, 1'b0);
    set_rand_bodies(2);
    do_write(1'b1, 1'b1);
    ref_err++;
    put(C_T, r128(), t);
    ref_err++;
    check_all("errors3");

    put(C_H, r128(), t);
    put(C_T, r128(), t);
    ref_err++;
    put(C_M, r128(), t);
    ref_err++;
    check_all("tail_in_meta");

    set_rand_bodies(2);
    send_pkt(16'h9004, 1'b0, 1'b0);
    set_rand_bodies(1);
    do_stat(1'b0);
    ref_err++;
    check_all("read_cancel");

    // Second status request lands while the first reply is still on its tail flit.
    set_rand_bodies(1);
    do_stat(1'b0);
    set_rand_bodies(1);
    send_pkt(16'h9002, 1'b1, 1'b0);
    ref_err++;
    check_all("reply_busy");

    do_run(1'b1, 2);
    check_all("run_before_reset");

    // Reset while reply flit 2 is on the output.
    a = {$urandom_range(1, 1023)};
    set_rand_bodies(1);
    b_a[0] = a;
    send_pkt(16'h9004, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midreset pkt_out_valid", 134'(pkt_out_valid), 134'(0));
    chk("midreset pkt_out", pkt_out, 134'(0));
    chk("midreset mem_addr", 134'(mem_addr), 134'(0));
    chk("midreset mem_wdata", 134'(mem_wdata), 134'(0));
    chk("midreset cpu_run", 134'(cpu_run), 134'(0));
    chk("midreset err_cnt", 134'(err_cnt), 134'(0));
    chk("midreset flits_seen", 134'(oq.size()), 134'(3));
    chk("midreset reads_seen", 134'(rq.size()), 134'(1));
    @(posedge clk);
    #1;
    reset = 1'b0;
    wq.delete(); rq.delete(); oq.delete();
    ew.delete(); er.delete(); eo.delete();
    ref_err    = 0;
    ref_run    = 1'b0;
    ref_wr_cnt = 32'd0;

    put(C_M, r128(), t);
    ref_err++;
    check_all("post_reset_idle");
    do_read($urandom, 2);
    check_all("post_reset_read");
    set_rand_bodies(1);
    do_stat(1'b1);
    check_all("post_reset_stat");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
